uart_broadcast_sequencer: RTL and testbench
===========================================

# uart_broadcast_sequencer

Sequences one inverter sample frame from the SPI sample source to all power-module UARTs. It requests a sample, latches `sin_index`/`uart_id`, and broadcasts two bytes to every UART TX instance, waiting for all of them to go idle after each byte. It then emits the global shoot pulse, waits a programmable gap, and repeats. It sits in the top-level FPGA design between the SPI request block and the `NUM_OF_MODULES` uart_tx instances, replacing the inline normal-mode FSM.

## Interface
Parameters:
- `NUM_MODULES`, 9: number of UART TX instances driven.
- `SHOOT_CYCLES`, 24: shoot pulse width in clk cycles (≥1).
- `GAP_CYCLES`, 256: idle cycles after shoot before the next request (≥1).
- `TIMEOUT_CYCLES`, 4096: maximum cycles spent in any wait state.
- `PIPE_CODE`, 12'hFFF: `sin_index` value that signals pipe mode.
- `PIPE_ID`, 4'hA: `uart_id` value that, together with `PIPE_CODE`, signals pipe mode.

Ports:
- `clk` in 1: single clock, 24 MHz from HFOSC.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: level; run the frame loop.
- `req_sample` out 1: one-cycle pulse to the SPI request block (start_transfer).
- `sample_valid` in 1: SPI data_valid; one-cycle pulse.
- `sin_index` in 12: sample index from SPI.
- `uart_id` in 4: module id from SPI.
- `data_to_tx` out 8: broadcast byte, common to all UARTs.
- `start_tx` out NUM_MODULES: per-UART start; all bits always equal.
- `tx_busy` in NUM_MODULES: per-UART busy.
- `shoot` out 1: shoot pulse.
- `frame_done` out 1: one-cycle pulse at the end of shoot.
- `pipe_req` out 1: one-cycle pulse when the pipe-mode code is received.
- `err_timeout` out 1: sticky; cleared by `err_clear`.
- `err_clear` in 1: synchronous clear of `err_timeout`.
- `state_dbg` out 4: current state encoding.

## Operation
- States and encodings:
  - IDLE = 0
  - REQUEST = 1
  - WAIT_SAMPLE = 2
  - SEND_HI = 3
  - WAIT_HI = 4
  - SEND_LO = 5
  - WAIT_LO = 6
  - SHOOT = 7
  - GAP = 8
- IDLE: go to REQUEST when `enable` = 1.
- REQUEST: pulse `req_sample`, then go to WAIT_SAMPLE.
- WAIT_SAMPLE: on `sample_valid`, latch `sin_index` and `uart_id`.
  - If the latched values equal {PIPE_CODE, PIPE_ID}: pulse `pipe_req` next cycle and go to IDLE; nothing is transmitted.
  - Otherwise go to SEND_HI.
- SEND_HI: `data_to_tx` = latched `sin_index[11:4]`; assert all `start_tx` bits for exactly 1 cycle; go to WAIT_HI.
- WAIT_HI: set a seen_busy flag when any `tx_busy` bit is 1. Go to SEND_LO once seen_busy = 1 and `tx_busy` = 0 on all bits.
- SEND_LO / WAIT_LO: same handshake as SEND_HI / WAIT_HI, with byte {`sin_index[3:0]`, `uart_id`}. WAIT_LO exits to SHOOT.
- SHOOT: `shoot` = 1 for SHOOT_CYCLES cycles. `frame_done` pulses in the cycle after the last shoot cycle, coincident with entry to GAP.
- GAP: count GAP_CYCLES cycles, then go to REQUEST if `enable` = 1, else IDLE.
- `enable` deasserted mid-frame: the frame completes through GAP, then goes to IDLE. A UART byte is never truncated.
- Timeout: a single counter clears on entry to WAIT_SAMPLE, WAIT_HI or WAIT_LO. If it reaches TIMEOUT_CYCLES before the exit condition:
  - `err_timeout` is set;
  - `start_tx` and `shoot` are driven 0;
  - the state goes to IDLE;
  - no shoot is issued for that frame.
- `err_timeout` stays at 1 until `err_clear`. If `err_clear` and a new timeout occur in the same cycle, set wins.
- `sample_valid` outside WAIT_SAMPLE is ignored.
- `tx_busy` is sampled only in the WAIT_* states.
- `data_to_tx` holds its value between bytes; it only changes in SEND_HI and SEND_LO.

## Timing
- Reset values, applied immediately and asynchronously:
  - all outputs 0;
  - state IDLE;
  - latched sample 0;
  - counters 0.
- Release: state leaves IDLE on the first rising edge at which `reset` = 1 and `enable` = 1.
- IDLE→REQUEST: 1 cycle after `enable` is seen; `req_sample` is high for that REQUEST cycle only.
- `sample_valid` at edge N → `start_tx` high in cycle N+1, with `data_to_tx` already valid in that cycle.
- Last busy bit falling at edge M in WAIT_HI → SEND_LO (`start_tx` high) in cycle M+1.
- Last busy bit falling in WAIT_LO at edge M → `shoot` rises in cycle M+1.
- Frame period with an ideal UART = 1 (REQUEST) + SPI latency + 2×(1 + byte time) + SHOOT_CYCLES + GAP_CYCLES.
- Counters are sized by $clog2 of their limit and saturate; none wrap.

## Test plan
- Normal frame: `enable`=1, SPI returns `sin_index`=12'hABC, `uart_id`=4'h3; UART model busy 10 cycles. Expect `data_to_tx` = 8'hAB then 8'hC3, each with a 1-cycle all-ones `start_tx`; `shoot` high 24 cycles; `frame_done` pulse; `req_sample` again 256 cycles later.
- Skewed modules: module 8 drops busy 5 cycles after the others. Expect SEND_LO to wait for module 8; no early start.
- Pipe code: `sin_index`=12'hFFF, `uart_id`=4'hA. Expect `pipe_req` pulse, no `start_tx`, no `shoot`, `state_dbg` = 0.
- Timeout: `tx_busy` never asserts. Expect `err_timeout`=1 exactly TIMEOUT_CYCLES after entering WAIT_HI, `shoot` never high, return to IDLE. Then assert `err_clear`; expect `err_timeout`=0 next cycle.
- Enable drop: deassert `enable` during WAIT_LO. Expect the second byte, shoot and gap to complete, then IDLE with no further `req_sample`.
- Async reset: pull `reset` low during SHOOT. Expect `shoot`, `start_tx` and `state_dbg` to be 0 before the next clock edge; restart from REQUEST after release.

Source files
------------

// File: rtl/uart_broadcast_sequencer.sv
// Frame sequencer: requests one SPI sample, broadcasts it as two bytes to every
// UART TX instance, then fires the shoot pulse and waits a programmable gap.
module uart_broadcast_sequencer #(
    parameter int unsigned NUM_MODULES    = 9,
    parameter int unsigned SHOOT_CYCLES   = 24,
    parameter int unsigned GAP_CYCLES     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [11:0] PIPE_CODE      = 12'hFFF,
    parameter logic [3:0]  PIPE_ID        = 4'hA
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   req_sample,
    input  logic                   sample_valid,
    input  logic [11:0]            sin_index,
    input  logic [3:0]             uart_id,
    output logic [7:0]             data_to_tx,
    output logic [NUM_MODULES-1:0] start_tx,
    input  logic [NUM_MODULES-1:0] tx_busy,
    output logic                   shoot,
    output logic                   frame_done,
    output logic                   pipe_req,
    output logic                   err_timeout,
    input  logic                   err_clear,
    output logic [3:0]             state_dbg
);
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        REQUEST     = 4'd1,
        WAIT_SAMPLE = 4'd2,
        SEND_HI     = 4'd3,
        WAIT_HI     = 4'd4,
        SEND_LO     = 4'd5,
        WAIT_LO     = 4'd6,
        SHOOT       = 4'd7,
        GAP         = 4'd8
    } state_t;

    // One shared counter serves the wait timeout, the shoot width and the gap.
    localparam int unsigned CNT_MAX_A = (SHOOT_CYCLES > GAP_CYCLES) ? SHOOT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
    localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(CNT_MAX - 1);
    localparam logic [CW-1:0] SHOOT_LAST = CW'(SHOOT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [7:0]    lo_byte;
    logic          seen_busy;
    logic          timeout_hit;
    logic          is_pipe;
    logic          all_idle;
    logic          wait_expired;

    always_comb begin
        state_next   = state;
        timeout_hit  = 1'b0;
        is_pipe      = (sin_index == PIPE_CODE) && (uart_id == PIPE_ID);
        all_idle     = ~|tx_busy;
        wait_expired = (cnt == TO_LAST);
        case (state)
            IDLE:        if (enable) state_next = REQUEST;
            REQUEST:     state_next = WAIT_SAMPLE;
            WAIT_SAMPLE: begin
                if (sample_valid) begin
                    state_next = is_pipe ? IDLE : SEND_HI;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            SEND_HI:     state_next = WAIT_HI;
            WAIT_HI: begin
                if (seen_busy && all_idle) begin
                    state_next = SEND_LO;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            SEND_LO:     state_next = WAIT_LO;
            WAIT_LO: begin
                if (seen_busy && all_idle) begin
                    state_next = SHOOT;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            SHOOT:       if (cnt == SHOOT_LAST) state_next = GAP;
            GAP:         if (cnt == GAP_LAST) state_next = enable ? REQUEST : IDLE;
            default:     state_next = IDLE;
        endcase
    end

    assign req_sample = (state == REQUEST);
    assign start_tx   = {NUM_MODULES{(state == SEND_HI) || (state == SEND_LO)}};
    assign shoot      = (state == SHOOT);
    assign state_dbg  = state;

    // data_to_tx is loaded on the edge that enters SEND_HI/SEND_LO so the byte
    // is already valid in the cycle start_tx is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lo_byte     <= '0;
            data_to_tx  <= '0;
            seen_busy   <= 1'b0;
            pipe_req    <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CW'(1);
            end

            pipe_req   <= 1'b0;
            frame_done <= 1'b0;

            if (state == WAIT_SAMPLE && sample_valid) begin
                lo_byte <= {sin_index[3:0], uart_id};
                if (is_pipe) begin
                    pipe_req <= 1'b1;
                end else begin
                    data_to_tx <= sin_index[11:4];
                end
            end

            if (state == WAIT_HI && state_next == SEND_LO) begin
                data_to_tx <= lo_byte;
            end

            if (state == SEND_HI || state == SEND_LO) begin
                seen_busy <= 1'b0;
            end else if ((state == WAIT_HI || state == WAIT_LO) && !all_idle) begin
                seen_busy <= 1'b1;
            end

            if (state == SHOOT && state_next == GAP) begin
                frame_done <= 1'b1;
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clear) begin
                err_timeout <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_broadcast_sequencer.sv
// Testbench for uart_broadcast_sequencer: SPI and UART responders plus event
// logs checked against frame timing derived from the sequencing rules.
module tb_uart_broadcast_sequencer;
    localparam int NM    = 9;
    localparam int SHOOT = 24;
    localparam int GAP   = 256;
    localparam int TMO   = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic          err_clear = 1'b0;
    logic [11:0]   sin_index = '0;
    logic [3:0]    uart_id = '0;
    logic [NM-1:0] tx_busy;
    logic          req_sample, shoot, frame_done, pipe_req, err_timeout;
    logic [7:0]    data_to_tx;
    logic [NM-1:0] start_tx;
    logic [3:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    uart_broadcast_sequencer #(
        .NUM_MODULES(NM), .SHOOT_CYCLES(SHOOT), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO),
        .PIPE_CODE(12'hFFF), .PIPE_ID(4'hA)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .req_sample(req_sample),
        .sample_valid(sample_valid), .sin_index(sin_index), .uart_id(uart_id),
        .data_to_tx(data_to_tx), .start_tx(start_tx), .tx_busy(tx_busy),
        .shoot(shoot), .frame_done(frame_done), .pipe_req(pipe_req),
        .err_timeout(err_timeout), .err_clear(err_clear), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // UART model: each module stays busy for blen cycles after its start pulse.
    int   blen [NM];
    int   bcnt [NM];
    logic uart_mute = 1'b0;
    always @(negedge clk) begin
        for (int i = 0; i < NM; i++) begin
            if (!reset) begin
                bcnt[i] = 0;
            end else begin
                if (bcnt[i] > 0) bcnt[i]--;
                if (start_tx[i] && !uart_mute) bcnt[i] = blen[i];
            end
            tx_busy[i] = (bcnt[i] > 0);
        end
    end

    int            cyc = 0;
    int            spi_due = -1;
    int            spi_lat = 0;
    logic [11:0]   spi_idx = '0;
    logic [3:0]    spi_id = '0;
    logic          err_last = 1'b0;
    int            req_q[$], start_q[$], shoot_q[$], done_q[$], pipe_q[$], err_q[$];
    logic [7:0]    byte_q[$];
    logic [NM-1:0] sval_q[$];
    logic [3:0]    pipe_st_q[$];

    task automatic clear_obs();
        req_q.delete(); start_q.delete(); shoot_q.delete(); done_q.delete();
        pipe_q.delete(); err_q.delete(); byte_q.delete(); sval_q.delete(); pipe_st_q.delete();
    endtask

    // Steps n falling edges, logging DUT events and acting as the SPI source.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (req_sample) begin
                req_q.push_back(cyc);
                spi_due = cyc + 1 + spi_lat;
            end
            if (|start_tx) begin
                start_q.push_back(cyc);
                byte_q.push_back(data_to_tx);
                sval_q.push_back(start_tx);
            end
            if (shoot) shoot_q.push_back(cyc);
            if (frame_done) done_q.push_back(cyc);
            if (pipe_req) begin
                pipe_q.push_back(cyc);
                pipe_st_q.push_back(state_dbg);
            end
            if (err_timeout && !err_last) err_q.push_back(cyc);
            err_last     = err_timeout;
            sample_valid = (cyc == spi_due);
            sin_index    = sample_valid ? spi_idx : 12'($urandom);
            uart_id      = sample_valid ? spi_id : 4'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; enable = 1'b0; sample_valid = 1'b0; err_clear = 1'b0; uart_mute = 1'b0;
        spi_due = -1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        err_last = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req_sample, start_tx, shoot, frame_done, pipe_req, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected all zero",
                     {req_sample, start_tx, shoot, frame_done, pipe_req, err_timeout});
        end
        checks++;
        if (state_dbg !== 4'd0 || data_to_tx !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got state=%0d data=%h expected 0/00", state_dbg, data_to_tx);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_obs();
        run_cycles(20);
        checks++;
        if (req_q.size() != 0 || state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL idle_no_enable: got reqs=%0d state=%0d expected 0/0", req_q.size(), state_dbg);
        end
    endtask

    task automatic test_frames();
        logic [11:0] idx;
        logic [3:0]  id;
        logic [7:0]  exp_hi, exp_lo;
        int lat, lmax, base, hi, lo, sh, nreq;
        for (int f = 0; f < 6; f++) begin
            if (f == 0) begin
                idx = 12'hABC; id = 4'h3;
            end else begin
                idx = 12'($urandom); id = 4'($urandom);
                if (idx == 12'hFFF && id == 4'hA) id = 4'h0;
            end
            lat  = (f == 0) ? 2 : int'($urandom_range(0, 7));
            lmax = 0;
            for (int i = 0; i < NM; i++) begin
                if (f < 2) blen[i] = (f == 1 && i == NM - 1) ? 15 : 10;
                else       blen[i] = int'($urandom_range(2, 16));
                if (blen[i] > lmax) lmax = blen[i];
            end
            exp_hi = idx[11:4];
            exp_lo = {idx[3:0], id};
            do_reset();
            clear_obs();
            spi_idx = idx; spi_id = id; spi_lat = lat; enable = 1'b1;
            base = cyc;
            hi   = base + 3 + lat;
            lo   = hi + lmax + 1;
            sh   = lo + lmax + 1;
            nreq = sh + SHOOT + GAP;
            run_cycles(nreq - base);

            checks++;
            if (req_q.size() != 2 || req_q[0] != base + 1 || req_q[1] != nreq) begin
                errors++;
                $display("FAIL frame%0d_req: got n=%0d at %0d,%0d expected n=2 at %0d,%0d",
                         f, req_q.size(), req_q[0], req_q[1], base + 1, nreq);
            end
            checks++;
            if (start_q.size() != 2 || start_q[0] != hi || start_q[1] != lo) begin
                errors++;
                $display("FAIL frame%0d_start: got n=%0d at %0d,%0d expected n=2 at %0d,%0d",
                         f, start_q.size(), start_q[0], start_q[1], hi, lo);
            end
            checks++;
            if (byte_q.size() != 2 || byte_q[0] !== exp_hi || byte_q[1] !== exp_lo) begin
                errors++;
                $display("FAIL frame%0d_bytes: got %h,%h expected %h,%h",
                         f, byte_q[0], byte_q[1], exp_hi, exp_lo);
            end
            checks++;
            if (sval_q.size() != 2 || sval_q[0] !== '1 || sval_q[1] !== '1) begin
                errors++;
                $display("FAIL frame%0d_start_all: got %b,%b expected all ones", f, sval_q[0], sval_q[1]);
            end
            checks++;
            if (shoot_q.size() != SHOOT || shoot_q[0] != sh || shoot_q[SHOOT-1] != sh + SHOOT - 1) begin
                errors++;
                $display("FAIL frame%0d_shoot: got n=%0d first=%0d expected n=%0d first=%0d",
                         f, shoot_q.size(), shoot_q[0], SHOOT, sh);
            end
            checks++;
            if (done_q.size() != 1 || done_q[0] != sh + SHOOT) begin
                errors++;
                $display("FAIL frame%0d_done: got n=%0d at %0d expected n=1 at %0d",
                         f, done_q.size(), done_q[0], sh + SHOOT);
            end
            checks++;
            if (data_to_tx !== exp_lo || pipe_q.size() != 0) begin
                errors++;
                $display("FAIL frame%0d_hold: got data=%h pipes=%0d expected %h/0",
                         f, data_to_tx, pipe_q.size(), exp_lo);
            end
        end
    endtask

    task automatic test_pipe();
        int lat, base;
        do_reset();
        clear_obs();
        lat = int'($urandom_range(0, 5));
        spi_idx = 12'hFFF; spi_id = 4'hA; spi_lat = lat;
        enable = 1'b1;
        base = cyc;
        run_cycles(1);
        enable = 1'b0;
        run_cycles(lat + 40);
        checks++;
        if (pipe_q.size() != 1 || pipe_q[0] != base + 3 + lat || pipe_st_q[0] !== 4'd0) begin
            errors++;
            $display("FAIL pipe_pulse: got n=%0d at %0d state=%0d expected n=1 at %0d state=0",
                     pipe_q.size(), pipe_q[0], pipe_st_q[0], base + 3 + lat);
        end
        checks++;
        if (start_q.size() != 0 || shoot_q.size() != 0 || req_q.size() != 1 || state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL pipe_quiet: got starts=%0d shoots=%0d reqs=%0d state=%0d expected 0/0/1/0",
                     start_q.size(), shoot_q.size(), req_q.size(), state_dbg);
        end
        // Same index with a different id is an ordinary sample.
        for (int i = 0; i < NM; i++) blen[i] = 10;
        clear_obs();
        spi_id = 4'hB;
        enable = 1'b1;
        base = cyc;
        run_cycles(1);
        enable = 1'b0;
        run_cycles(lat + 10);
        checks++;
        if (pipe_q.size() != 0 || start_q.size() != 1 || start_q[0] != base + 3 + lat || byte_q[0] !== 8'hFF) begin
            errors++;
            $display("FAIL near_pipe: got pipes=%0d starts=%0d at %0d byte=%h expected 0/1 at %0d ff",
                     pipe_q.size(), start_q.size(), start_q[0], byte_q[0], base + 3 + lat);
        end
    endtask

    task automatic test_timeout();
        int lat, base, hi;
        do_reset();
        clear_obs();
        uart_mute = 1'b1;
        lat = int'($urandom_range(0, 4));
        spi_lat = lat; spi_idx = 12'h5A5; spi_id = 4'h6;
        enable = 1'b1;
        base = cyc;
        run_cycles(1);
        enable = 1'b0;
        hi = base + 3 + lat;
        run_cycles(hi + TMO + 4 - cyc);
        checks++;
        if (err_q.size() != 1 || err_q[0] != hi + TMO + 1) begin
            errors++;
            $display("FAIL timeout_time: got n=%0d at %0d expected n=1 at %0d", err_q.size(), err_q[0], hi + TMO + 1);
        end
        checks++;
        if (shoot_q.size() != 0 || start_q.size() != 1 || state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL timeout_abort: got shoots=%0d starts=%0d state=%0d expected 0/1/0",
                     shoot_q.size(), start_q.size(), state_dbg);
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected 1", err_timeout);
        end
        err_clear = 1'b1;
        run_cycles(1);
        err_clear = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", err_timeout);
        end
        // Clear held through a second timeout: the set takes priority.
        clear_obs();
        err_clear = 1'b1;
        enable = 1'b1;
        base = cyc;
        run_cycles(1);
        enable = 1'b0;
        hi = base + 3 + lat;
        run_cycles(hi + TMO + 1 - cyc);
        checks++;
        if (err_timeout !== 1'b1 || err_q.size() != 1 || err_q[0] != hi + TMO + 1) begin
            errors++;
            $display("FAIL set_wins: got err=%b n=%0d at %0d expected 1 n=1 at %0d",
                     err_timeout, err_q.size(), err_q[0], hi + TMO + 1);
        end
        run_cycles(1);
        err_clear = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_set: got %b expected 0", err_timeout);
        end
    endtask

    task automatic test_enable_drop();
        int lat, lmax, base, hi, lo, sh;
        logic [11:0] idx;
        do_reset();
        clear_obs();
        lmax = 0;
        for (int i = 0; i < NM; i++) begin
            blen[i] = int'($urandom_range(2, 12));
            if (blen[i] > lmax) lmax = blen[i];
        end
        lat = int'($urandom_range(0, 5));
        idx = 12'h7E1;
        spi_idx = idx; spi_id = 4'h2; spi_lat = lat;
        enable = 1'b1;
        base = cyc;
        hi = base + 3 + lat;
        lo = hi + lmax + 1;
        sh = lo + lmax + 1;
        run_cycles(lo + 2 - base);
        enable = 1'b0;
        run_cycles(sh + SHOOT + GAP + 20 - cyc);
        checks++;
        if (start_q.size() != 2 || start_q[1] != lo || byte_q[1] !== 8'h12) begin
            errors++;
            $display("FAIL drop_second_byte: got n=%0d at %0d byte=%h expected n=2 at %0d 12",
                     start_q.size(), start_q[1], byte_q[1], lo);
        end
        checks++;
        if (shoot_q.size() != SHOOT || shoot_q[0] != sh || done_q.size() != 1 || done_q[0] != sh + SHOOT) begin
            errors++;
            $display("FAIL drop_shoot: got n=%0d first=%0d done=%0d expected n=%0d first=%0d done=%0d",
                     shoot_q.size(), shoot_q[0], done_q[0], SHOOT, sh, sh + SHOOT);
        end
        checks++;
        if (req_q.size() != 1 || state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL drop_idle: got reqs=%0d state=%0d expected 1/0", req_q.size(), state_dbg);
        end
    endtask

    task automatic test_async_reset();
        int base, sh;
        do_reset();
        clear_obs();
        for (int i = 0; i < NM; i++) blen[i] = 10;
        spi_idx = 12'h321; spi_id = 4'h7; spi_lat = 1;
        enable = 1'b1;
        base = cyc;
        sh = base + 3 + 1 + 2 * 11;
        run_cycles(sh + 5 - base);
        checks++;
        if (shoot !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_shoot: got %b expected 1", shoot);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (shoot !== 1'b0 || start_tx !== '0 || state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got shoot=%b start=%b state=%0d expected 0/0/0", shoot, start_tx, state_dbg);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        spi_due = -1;
        err_last = 1'b0;
        clear_obs();
        base = cyc;
        run_cycles(3);
        checks++;
        if (req_q.size() != 1 || req_q[0] != base + 1) begin
            errors++;
            $display("FAIL restart_req: got n=%0d at %0d expected n=1 at %0d", req_q.size(), req_q[0], base + 1);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_pipe();
        test_timeout();
        test_enable_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
